pid_plant_model: RTL and testbench



---
 rtl/pid_plant_model.sv | 118 +++++++++++
 tb/tb_pid_plant_model.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_plant_model.sv
// rtl/pid_plant_model.sv - first-order-lag plant with transport delay and disturbance
// Closes the loop around pid_controller: takes its 8-bit control signal and
// returns the 8-bit feedback it reads, updated once every DIV clocks.
// Optional build macro: PID_PLANT_NOISE_EN adds +/-1 LFSR noise at the output.
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   run          1 = prescaler counts and plant updates, 0 = everything frozen
//   control      unsigned actuator input (controller's control_signal)
//   delay_sel    transport delay in samples, 0..7
//   disturbance  signed two's-complement offset added at the plant output
//   feedback     saturated plant output, registered
//   sample_tick  pulse in the cycle the updated feedback first appears
module pid_plant_model #(
  parameter int unsigned DIV        = 16,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned INIT_LEVEL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] control,
  input  logic [2:0] delay_sel,
  input  logic [7:0] disturbance,
  output logic [7:0] feedback,
  output logic       sample_tick
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [7:0]    INIT_U8  = 8'(INIT_LEVEL);

  logic [CW-1:0]      count;
  logic               tick;
  logic               tick_d;
  logic [7:0]         line [7];
  logic [15:0]        y_acc;
  logic [7:0]         u_eff;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [9:0]  sum;
  logic [7:0]         sat;

  // Dropping run on the terminal count suppresses that tick.
  assign tick = run && (count == CNT_LAST);

  // Input seen by the lag: live control, or the value captured d ticks ago.
  always_comb begin
    u_eff = control;
    for (int k = 1; k < 8; k++) begin
      if (delay_sel == 3'(k)) u_eff = line[k-1];
    end
  end

  // Move 1/2^SHIFT of the way toward the target; the arithmetic shift floors,
  // so the new value always lies between old y_acc and u_eff<<8.
  assign diff = $signed({1'b0, u_eff, 8'h00}) - $signed({1'b0, y_acc});
  assign step = diff >>> SHIFT;

`ifdef PID_PLANT_NOISE_EN
  logic [7:0]        lfsr;
  logic signed [9:0] noise;

  assign noise = lfsr[0] ? 10'sd1 : -10'sd1;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per plant sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (tick) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign sum = $signed({2'b00, y_acc[15:8]})
             + $signed({{2{disturbance[7]}}, disturbance})
             + noise;
`else
  assign sum = $signed({2'b00, y_acc[15:8]})
             + $signed({{2{disturbance[7]}}, disturbance});
`endif

  always_comb begin
    if (sum[9]) begin
      sat = 8'h00;
    end else if (sum[8]) begin
      sat = 8'hFF;
    end else begin
      sat = sum[7:0];
    end
  end

  // y_acc updates on the tick edge and feedback one edge later, so
  // sample_tick runs through two flops to line up with that feedback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      tick_d      <= 1'b0;
      sample_tick <= 1'b0;
      y_acc       <= {INIT_U8, 8'h00};
      feedback    <= INIT_U8;
      for (int k = 0; k < 7; k++) line[k] <= INIT_U8;
    end else begin
      tick_d      <= tick;
      sample_tick <= tick_d;
      feedback    <= sat;
      if (run) begin
        count <= tick ? '0 : count + CW'(1);
      end
      if (tick) begin
        y_acc   <= 16'($signed({1'b0, y_acc}) + step);
        line[0] <= control;
        for (int k = 1; k < 7; k++) line[k] <= line[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pid_plant_model.sv
// tb/tb_pid_plant_model.sv - self-checking bench for pid_plant_model
module tb_pid_plant_model;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] control = 8'd0;
  logic [2:0] delay_sel = 3'd0;
  logic [7:0] disturbance = 8'd0;
  logic [7:0] fb_a, fb_b;
  logic       st_a, st_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state, one slot per DUT instance.
  int         divs[2]   = '{16, 1};
  int         shifts[2] = '{2, 0};
  int         inits[2]  = '{0, 40};
  int         y[2];
  int         nrun[2];
  int         hist[2][7];
  logic       tickp[2];
  logic [7:0] efb[2];
  logic       est[2];

  int step_exp[3]  = '{50, 87, 115};
  int delay_exp[5] = '{0, 0, 0, 25, 43};
  int rst_exp[3]   = '{0, 0, 45};

  always #5 clk = ~clk;

  pid_plant_model #(.DIV(16), .SHIFT(2), .INIT_LEVEL(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .control(control),
    .delay_sel(delay_sel), .disturbance(disturbance),
    .feedback(fb_a), .sample_tick(st_a)
  );

  pid_plant_model #(.DIV(1), .SHIFT(0), .INIT_LEVEL(40)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .control(control),
    .delay_sel(delay_sel), .disturbance(disturbance),
    .feedback(fb_b), .sample_tick(st_b)
  );

  function automatic int floor_div(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      y[i]     = inits[i] * 256;
      nrun[i]  = 0;
      tickp[i] = 1'b0;
      efb[i]   = 8'(inits[i]);
      est[i]   = 1'b0;
      for (int k = 0; k < 7; k++) hist[i][k] = inits[i];
    end
  endtask

  // Plant behaviour per clock: every DIV-th running clock is a sample;
  // outputs seen after an edge come from the state before that edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int   level;
      int   u;
      int   d;
      logic tk;
      level = y[i] / 256 + int'($signed(disturbance));
      if (level < 0) level = 0;
      else if (level > 255) level = 255;
      efb[i] = 8'(level);
      est[i] = tickp[i];
      tk = 1'b0;
      if (run) begin
        nrun[i]++;
        tk = (nrun[i] % divs[i]) == 0;
      end
      if (tk) begin
        u = (delay_sel == 3'd0) ? int'(control) : hist[i][int'(delay_sel) - 1];
        d = u * 256 - y[i];
        y[i] = y[i] + floor_div(d, 1 << shifts[i]);
        for (int k = 6; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = int'(control);
      end
      tickp[i] = tk;
    end
  endtask

  task automatic step();
    if (!rst_n) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0;
    control = 8'd200;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if (fb_a !== 8'd0 || st_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold_a cyc=%0d got st=%0b fb=%0d want st=0 fb=0", cyc, st_a, fb_a);
      end
      total++;
      if ({st_b, fb_b} !== {est[1], efb[1]}) begin
        bad++;
        $display("FAIL reset_hold_b cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_b, fb_b, est[1], efb[1]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]}) begin
        bad++;
        $display("FAIL idle_a cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_a, fb_a, est[0], efb[0]);
      end
    end
  endtask

  task automatic test_step_response();
    control = 8'd200;
    delay_sel = 3'd0;
    disturbance = 8'd0;
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 49; i++) begin
      step();
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]}) begin
        bad++;
        $display("FAIL step_a cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_a, fb_a, est[0], efb[0]);
      end
      total++;
      if ({st_b, fb_b} !== {est[1], efb[1]}) begin
        bad++;
        $display("FAIL step_b cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_b, fb_b, est[1], efb[1]);
      end
      if (i > 1 && i % 16 == 1) begin
        total++;
        if (st_a !== 1'b1 || fb_a !== 8'(step_exp[i/16 - 1])) begin
          bad++;
          $display("FAIL step_point clk=%0d got st=%0b fb=%0d want st=1 fb=%0d", i, st_a, fb_a, step_exp[i/16 - 1]);
        end
      end
    end
  endtask

  task automatic test_transport_delay();
    control = 8'd0;
    delay_sel = 3'd3;
    disturbance = 8'd0;
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 81; i++) begin
      if (i == 5) control = 8'd100;
      step();
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]}) begin
        bad++;
        $display("FAIL delay_a cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_a, fb_a, est[0], efb[0]);
      end
      total++;
      if ({st_b, fb_b} !== {est[1], efb[1]}) begin
        bad++;
        $display("FAIL delay_b cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_b, fb_b, est[1], efb[1]);
      end
      if (i > 1 && i % 16 == 1) begin
        total++;
        if (st_a !== 1'b1 || fb_a !== 8'(delay_exp[i/16 - 1])) begin
          bad++;
          $display("FAIL delay_point tick=%0d got st=%0b fb=%0d want st=1 fb=%0d", i/16, st_a, fb_a, delay_exp[i/16 - 1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    delay_sel = 3'd0;
    control = 8'd250;
    disturbance = 8'd0;
    run = 1'b1;
    for (int i = 0; i < 640; i++) begin
      step();
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]}) begin
        bad++;
        $display("FAIL settle_hi_a cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_a, fb_a, est[0], efb[0]);
      end
    end
    total++;
    if (fb_b !== 8'd250) begin
      bad++;
      $display("FAIL settle_hi_b got fb=%0d want fb=250", fb_b);
    end
    disturbance = 8'd20;
    step();
    total++;
    if (fb_b !== 8'd255 || fb_a !== 8'd255) begin
      bad++;
      $display("FAIL sat_high got a=%0d b=%0d want a=255 b=255", fb_a, fb_b);
    end
    control = 8'd50;
    disturbance = 8'h80;
    for (int i = 0; i < 640; i++) begin
      step();
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]}) begin
        bad++;
        $display("FAIL settle_lo_a cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_a, fb_a, est[0], efb[0]);
      end
    end
    total++;
    if (fb_b !== 8'd0 || fb_a !== 8'd0) begin
      bad++;
      $display("FAIL sat_low got a=%0d b=%0d want a=0 b=0", fb_a, fb_b);
    end
    disturbance = 8'd226;
    step();
    total++;
    if (fb_b !== 8'd20) begin
      bad++;
      $display("FAIL neg_offset got fb=%0d want fb=20", fb_b);
    end
    disturbance = 8'd0;
  endtask

  task automatic test_run_pause();
    control = 8'd200;
    delay_sel = 3'd0;
    disturbance = 8'd0;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 25; i++) step();
    run = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      total++;
      if (st_a !== 1'b0 || fb_a !== 8'd50) begin
        bad++;
        $display("FAIL pause_hold cyc=%0d got st=%0b fb=%0d want st=0 fb=50", cyc, st_a, fb_a);
      end
      total++;
      if ({st_b, fb_b} !== {est[1], efb[1]}) begin
        bad++;
        $display("FAIL pause_b cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_b, fb_b, est[1], efb[1]);
      end
    end
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (st_a !== (i == 8) || (i == 8 && fb_a !== 8'd87)) begin
        bad++;
        $display("FAIL resume i=%0d got st=%0b fb=%0d want st=%0b fb=87", i, st_a, fb_a, i == 8);
      end
    end
    for (int i = 0; i < 14; i++) step();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]} || st_a !== 1'b0) begin
        bad++;
        $display("FAIL tick_suppress cyc=%0d got st=%0b fb=%0d want st=0 fb=%0d", cyc, st_a, fb_a, efb[0]);
      end
    end
    run = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      total++;
      if (st_a !== (i == 2) || (i == 2 && fb_a !== 8'd115)) begin
        bad++;
        $display("FAIL after_suppress i=%0d got st=%0b fb=%0d want st=%0b fb=115", i, st_a, fb_a, i == 2);
      end
    end
  endtask

  task automatic test_async_reset();
    delay_sel = 3'd2;
    control = 8'd180;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (fb_a !== 8'd0 || st_a !== 1'b0 || fb_b !== 8'd40) begin
      bad++;
      $display("FAIL async_clear got a=%0d st=%0b b=%0d want a=0 st=0 b=40", fb_a, st_a, fb_b);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 49; i++) begin
      step();
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]}) begin
        bad++;
        $display("FAIL post_rst_a cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_a, fb_a, est[0], efb[0]);
      end
      total++;
      if ({st_b, fb_b} !== {est[1], efb[1]}) begin
        bad++;
        $display("FAIL post_rst_b cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_b, fb_b, est[1], efb[1]);
      end
      if (i > 1 && i % 16 == 1) begin
        total++;
        if (st_a !== 1'b1 || fb_a !== 8'(rst_exp[i/16 - 1])) begin
          bad++;
          $display("FAIL post_rst_point tick=%0d got st=%0b fb=%0d want st=1 fb=%0d", i/16, st_a, fb_a, rst_exp[i/16 - 1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) control = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) delay_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) disturbance = 8'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 599) != 0);
      step();
      rst_n = 1'b1;
      total++;
      if ({st_a, fb_a} !== {est[0], efb[0]}) begin
        bad++;
        $display("FAIL random_a cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_a, fb_a, est[0], efb[0]);
      end
      total++;
      if ({st_b, fb_b} !== {est[1], efb[1]}) begin
        bad++;
        $display("FAIL random_b cyc=%0d got st=%0b fb=%0d want st=%0b fb=%0d", cyc, st_b, fb_b, est[1], efb[1]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step_response();
    test_transport_delay();
    test_saturation();
    test_run_pause();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
